// File: rtl/stmt_lowerer_seq_serializer.sv
// ---------------------------------------------------------------------------
// stmt_lowerer_seq_serializer
//
// Transmit end of a framed serial link. A parallel word is accepted over a
// valid/ready handshake and shifted out on tx as
//     start(0) / data LSB first / optional parity / stop(1)
// with every serial bit held for DIV clock cycles.
//
// Ports:
//   clk              single clock, rising edge
//   rst              asynchronous, active-high reset
//   in_valid         producer has a word
//   in_ready         block can accept a word (high only in IDLE)
//   in_data          word to send (DATA_WIDTH bits)
//   parity_mode      2'b0? none, 2'b10 even, 2'b11 odd (sampled on accept)
//   tx               serial line, idles high, registered
//   busy             frame in progress
//   frame_count      completed frames, wraps 255 -> 0
//   first_one_idx    index of lowest set bit of the last accepted word
//   first_one_valid  last accepted word was nonzero
// ---------------------------------------------------------------------------
module stmt_lowerer_seq_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            parity_mode,
    output logic                  tx,
    output logic                  busy,
    output logic [7:0]            frame_count,
    output logic [((DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1)-1:0] first_one_idx,
    output logic                  first_one_valid
);

    // A 1-bit payload or DIV of 1 would give zero-width counters; keep them
    // at least one bit wide so the same code covers every legal parameter.
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(DATA_WIDTH - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]            state_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [1:0]            mode_reg;
    logic                  parity_reg;      // XOR of the accepted word
    logic [IDX_W-1:0]      bit_cnt_reg;
    logic [DIV_W-1:0]      div_cnt_reg;
    logic                  tx_reg;
    logic [7:0]            frame_count_reg;
    logic [IDX_W-1:0]      first_one_idx_reg;
    logic                  first_one_valid_reg;

    logic                  accept;
    logic                  div_last;
    logic [DATA_WIDTH-1:0] shift_shr;
    logic [IDX_W-1:0]      scan_idx;
    logic                  scan_found;

    assign in_ready        = (state_reg == ST_IDLE);
    assign busy            = (state_reg != ST_IDLE);
    assign tx              = tx_reg;
    assign frame_count     = frame_count_reg;
    assign first_one_idx   = first_one_idx_reg;
    assign first_one_valid = first_one_valid_reg;

    assign accept   = in_valid && in_ready;
    assign div_last = (div_cnt_reg == DIV_LAST);

    // Shift register moved one place toward the LSB, zero filling the top.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_shr
            if (gi == DATA_WIDTH - 1) begin : g_top
                assign shift_shr[gi] = 1'b0;
            end else begin : g_mid
                assign shift_shr[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    // Lowest set bit of the incoming word: ascending scan, stop at first hit.
    always_comb begin
        scan_idx   = '0;
        scan_found = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (in_data[i]) begin
                scan_idx   = IDX_W'(i);
                scan_found = 1'b1;
                break;
            end
        end
    end

    // tx is registered, so every transition loads the line value of the
    // state/bit being entered; that keeps each bit exactly DIV cycles wide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg           <= ST_IDLE;
            shift_reg           <= '0;
            mode_reg            <= 2'b00;
            parity_reg          <= 1'b0;
            bit_cnt_reg         <= '0;
            div_cnt_reg         <= '0;
            tx_reg              <= 1'b1;
            frame_count_reg     <= 8'd0;
            first_one_idx_reg   <= '0;
            first_one_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (accept) begin
                        shift_reg   <= in_data;
                        mode_reg    <= parity_mode;
                        parity_reg  <= ^in_data;
                        {first_one_valid_reg, first_one_idx_reg} <= {scan_found, scan_idx};
                        bit_cnt_reg <= '0;
                        div_cnt_reg <= '0;
                        tx_reg      <= 1'b0;
                        state_reg   <= ST_START;
                    end
                end

                ST_START: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        tx_reg      <= shift_reg[0];
                        state_reg   <= ST_DATA;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end

                ST_DATA: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        if (bit_cnt_reg == BIT_LAST) begin
                            casez (mode_reg)
                                2'b0?: begin
                                    tx_reg    <= 1'b1;
                                    state_reg <= ST_STOP;
                                end
                                2'b10: begin
                                    tx_reg    <= parity_reg;
                                    state_reg <= ST_PARITY;
                                end
                                default: begin
                                    tx_reg    <= ~parity_reg;
                                    state_reg <= ST_PARITY;
                                end
                            endcase
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + IDX_W'(1);
                            shift_reg   <= shift_shr;
                            tx_reg      <= shift_shr[0];
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end

                ST_PARITY: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        tx_reg      <= 1'b1;
                        state_reg   <= ST_STOP;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end

                ST_STOP: begin
                    if (div_last) begin
                        div_cnt_reg     <= '0;
                        tx_reg          <= 1'b1;
                        frame_count_reg <= frame_count_reg + 8'd1;
                        state_reg       <= ST_IDLE;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end

                default: begin
                    div_cnt_reg <= '0;
                    tx_reg      <= 1'b1;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stmt_lowerer_seq_serializer.sv
// ---------------------------------------------------------------------------
// tb_stmt_lowerer_seq_serializer
//
// Two serializers share one clock: unit 0 with DIV=4 and unit 1 with DIV=1,
// both 8-bit payloads. Each frame's expected line waveform is built from the
// framing rules as a list of bits, each repeated DIV times, and compared with
// tx cycle by cycle. Inputs are driven and outputs sampled on the falling
// edge. One line is printed per frame.
// ---------------------------------------------------------------------------
module tb_stmt_lowerer_seq_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a      [2];
    logic       in_valid_a [2];
    logic       in_ready_a [2];
    logic [7:0] in_data_a  [2];
    logic [1:0] mode_a     [2];
    logic       tx_a       [2];
    logic       busy_a     [2];
    logic [7:0] fcount_a   [2];
    logic [2:0] fidx_a     [2];
    logic       fvalid_a   [2];

    logic [7:0] exp_count [2];
    int n_cmp = 0;
    int n_bad = 0;

    stmt_lowerer_seq_serializer #(.DATA_WIDTH(8), .DIV(4)) dut0 (
        .clk             (clk),
        .rst             (rst_a[0]),
        .in_valid        (in_valid_a[0]),
        .in_ready        (in_ready_a[0]),
        .in_data         (in_data_a[0]),
        .parity_mode     (mode_a[0]),
        .tx              (tx_a[0]),
        .busy            (busy_a[0]),
        .frame_count     (fcount_a[0]),
        .first_one_idx   (fidx_a[0]),
        .first_one_valid (fvalid_a[0])
    );

    stmt_lowerer_seq_serializer #(.DATA_WIDTH(8), .DIV(1)) dut1 (
        .clk             (clk),
        .rst             (rst_a[1]),
        .in_valid        (in_valid_a[1]),
        .in_ready        (in_ready_a[1]),
        .in_data         (in_data_a[1]),
        .parity_mode     (mode_a[1]),
        .tx              (tx_a[1]),
        .busy            (busy_a[1]),
        .frame_count     (fcount_a[1]),
        .first_one_idx   (fidx_a[1]),
        .first_one_valid (fvalid_a[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int div_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    // Checks the idle/reset-visible outputs of unit u.
    task automatic check_idle(input int u, input string tag);
        check_eq({tag, "_tx"},       tx_a[u],       1);
        check_eq({tag, "_busy"},     busy_a[u],     0);
        check_eq({tag, "_in_ready"}, in_ready_a[u], 1);
        check_eq({tag, "_fcount"},   fcount_a[u],   exp_count[u]);
    endtask

    // Called on a falling edge with unit u idle. Presents one word, then
    // follows the whole frame; returns on the first idle falling edge, so an
    // immediately following call accepts after exactly one idle cycle.
    // With scramble set, in_valid/in_data change randomly and parity_mode is
    // forced to odd while the frame is in flight.
    task automatic send_frame(input int u, input logic [7:0] d, input logic [1:0] m,
                              input bit scramble);
        logic bits[$];
        int   div;
        int   ones;
        int   low;
        div  = div_of(u);
        ones = $countones(d);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (m == 2'b10) bits.push_back((ones % 2) == 1);
        if (m == 2'b11) bits.push_back((ones % 2) == 0);
        bits.push_back(1'b1);
        low = 0;
        if (d != 8'h00) while (d[low] == 1'b0) low++;

        $display("frame unit=%0d data=%02h mode=%b scramble=%0d len=%0d",
                 u, d, m, scramble, bits.size() * div);
        check_eq("ready_before_accept", in_ready_a[u], 1);
        in_valid_a[u] = 1'b1;
        in_data_a[u]  = d;
        mode_a[u]     = m;
        @(negedge clk);
        check_eq("first_one_idx",   fidx_a[u],   low);
        check_eq("first_one_valid", fvalid_a[u], (d != 8'h00));
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < div; c++) begin
                check_eq($sformatf("tx_bit%0d", b), tx_a[u], bits[b]);
                check_eq("in_ready_busy", in_ready_a[u], 0);
                if (scramble) begin
                    in_valid_a[u] = 1'($urandom);
                    in_data_a[u]  = 8'($urandom);
                    mode_a[u]     = 2'b11;
                end else begin
                    in_valid_a[u] = 1'b0;
                end
                @(negedge clk);
            end
        end
        exp_count[u] = exp_count[u] + 8'd1;
        check_idle(u, "frame_end");
        in_valid_a[u] = 1'b0;
    endtask

    // Starts word d on unit u and asserts reset between clock edges once the
    // frame has run cyc cycles; reset must act before the next rising edge.
    task automatic reset_mid(input int u, input logic [7:0] d, input int cyc);
        int bi;
        logic exp_tx;
        $display("reset unit=%0d data=%02h at cycle %0d", u, d, cyc);
        in_valid_a[u] = 1'b1;
        in_data_a[u]  = d;
        mode_a[u]     = 2'b00;
        @(negedge clk);
        in_valid_a[u] = 1'b0;
        repeat (cyc) @(negedge clk);
        bi = cyc / div_of(u);
        exp_tx = (bi == 0) ? 1'b0 : d[bi-1];
        check_eq("tx_before_rst",   tx_a[u],   exp_tx);
        check_eq("busy_before_rst", busy_a[u], 1);
        #2 rst_a[u] = 1'b1;
        #1;
        exp_count[u] = 8'd0;
        check_idle(u, "async_rst");
        check_eq("async_rst_fvalid", fvalid_a[u], 0);
        check_eq("async_rst_fidx",   fidx_a[u],   0);
        @(negedge clk);
        rst_a[u] = 1'b0;
        check_idle(u, "after_rst");
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_a[u]      = 1'b1;
            in_valid_a[u] = 1'b0;
            in_data_a[u]  = 8'h00;
            mode_a[u]     = 2'b00;
            exp_count[u]  = 8'd0;
        end
        #1;
        for (int u = 0; u < 2; u++) begin
            check_idle(u, "reset");
            check_eq("reset_fidx",   fidx_a[u],   0);
            check_eq("reset_fvalid", fvalid_a[u], 0);
        end
        @(negedge clk);
        rst_a[0] = 1'b0;
        rst_a[1] = 1'b0;
        @(negedge clk);

        // Plain frame, no parity.
        send_frame(0, 8'hA5, 2'b00, 0);
        // Even then odd parity on a word with three ones.
        send_frame(0, 8'h07, 2'b10, 0);
        send_frame(0, 8'h07, 2'b11, 0);
        // Back-to-back words with first-one edge cases.
        send_frame(0, 8'h01, 2'b00, 0);
        send_frame(0, 8'h80, 2'b00, 0);
        send_frame(0, 8'h00, 2'b00, 0);
        // Mode changed to odd mid-frame is ignored; next frame uses it.
        repeat (2) @(negedge clk);
        send_frame(0, 8'h5A, 2'b00, 1);
        send_frame(0, 8'h3C, 2'b11, 0);

        // Reset during DATA bit 3, and during START where tx is low.
        reset_mid(0, 8'hFF, 17);
        send_frame(0, 8'hC3, 2'b10, 0);
        reset_mid(0, 8'h00, 2);
        send_frame(0, 8'h81, 2'b11, 0);

        // Random words, modes, gaps and in-flight input noise.
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_frame(0, 8'($urandom), 2'($urandom), 1'($urandom));
        end

        // DIV=1 unit: 256 back-to-back frames wrap the frame counter.
        for (int k = 0; k < 256; k++) begin
            send_frame(1, 8'($urandom), 2'b00, 0);
        end
        check_eq("frame_count_wrap", fcount_a[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stmt_lowerer_seq_serializer.md
Name: stmt_lowerer_seq_serializer

Overview:
Sequential companion to the combinational statement-lowering fixtures. It is the transmit end of a framed serial link: it accepts a parallel word over a valid/ready handshake and shifts it out as start / data (LSB first) / optional parity / stop.
It exercises always_ff lowering of case-based FSMs, casez decode, a for-loop with break, LHS bit/part-select and concat writes, and asynchronous reset.
It is both a converter regression fixture and a reusable serializer.

Parameters:
DATA_WIDTH, 8, payload bits per frame (1..32)
DIV, 4, clock cycles per serial bit (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  producer has a word
in_ready  output  1  block can accept a word; equals (state==IDLE)
in_data  input  DATA_WIDTH  word to send
parity_mode  input  2  casez decode: 2'b0? none, 2'b10 even, 2'b11 odd
tx  output  1  serial line, idle high
busy  output  1  frame in progress (state!=IDLE)
frame_count  output  8  completed frames, wraps 255->0
first_one_idx  output  $clog2(DATA_WIDTH)  index of lowest set bit of last accepted word
first_one_valid  output  1  last accepted word was nonzero

Behaviour:
- Reset (async, takes effect immediately, independent of clk):
  - state=IDLE, tx=1, busy=0, in_ready=1.
  - frame_count=0, first_one_idx=0, first_one_valid=0.
  - Shift register, bit counter and divider counter all 0.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept:
  - A word is accepted on the rising edge where in_valid && in_ready.
  - On that edge: latch in_data into the shift register and latch parity_mode (later changes to parity_mode are ignored until the next accept).
  - Compute the even/odd parity bit from in_data.
  - Compute first_one_idx/first_one_valid using an ascending for-loop with break. If in_data==0: first_one_idx=0, first_one_valid=0.
  - Next state is START. tx is registered and becomes 0 from the cycle after the accept edge.
- Bit timing:
  - Each state holds tx constant for exactly DIV cycles, counted by a divider counter 0..DIV-1.
  - The divider counter resets to 0 on every state or bit change.
- DATA: tx = shift[0]. After each DIV-cycle bit, shift right by one. The bit counter runs 0..DATA_WIDTH-1.
- After DATA, go to PARITY if the latched mode is 2'b1?, otherwise go directly to STOP.
- PARITY bit values:
  - Even mode: XOR of the data bits (total ones count, including the parity bit, is even).
  - Odd mode: the inverse of that.
- STOP: tx=1 for DIV cycles. On the last STOP cycle's edge: go to IDLE and frame_count increments, wrapping modulo 256.
- Frame length is (2 + DATA_WIDTH + P) * DIV cycles, with P = 1 if parity is enabled, else 0. in_ready is low for exactly this many cycles after an accept.
- Back-to-back: in_ready rises in the first IDLE cycle. If in_valid is already high, the next accept happens on that edge, so there is one IDLE cycle between frames and tx stays 1 during it.
- in_valid held high while busy is ignored (no accept, no state effect).
- in_data changes while busy have no effect.
- DIV=1: one cycle per bit, no special-casing.
- Reset asserted mid-frame: tx returns to 1 immediately, the in-flight word is dropped, and frame_count is cleared.

Test Plan:
1. Reset, then send 0xA5, DIV=4, parity_mode=2'b00 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. in_ready low for 40 cycles. frame_count=1. first_one_idx=0, first_one_valid=1.
2. Send 0x07 with parity_mode=2'b10, then again with 2'b11 -> parity bit 1 (even), then 0 (odd). Frame length 44 cycles each.
3. Hold in_valid high with three queued words 0x01, 0x80, 0x00 -> exactly one idle-high cycle between frames. first_one_idx = 0, 7, 0. first_one_valid = 1, 1, 0 respectively.
4. Assert rst during DATA bit 3 of 0xFF -> tx=1 in the same cycle (before the next clk edge). busy=0, frame_count=0, in_ready=1. The next word transmits cleanly.
5. Send 256 frames with DIV=1 -> frame_count wraps to 0. Each frame is 10 cycles long plus 1 idle cycle.
6. Toggle parity_mode from 2'b00 to 2'b11 mid-frame -> no parity bit is emitted for that frame. The following accepted frame does include an odd parity bit.
